// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the decode control logic (master) and the
// program counter sequencer (slave).
interface pc_sequencer_if #(
   parameter int WIDTH       = 32,
   parameter int STACK_DEPTH = 4
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   logic               start;
   logic               halt_req;
   logic               stall;
   logic               branch;
   logic               call;
   logic               ret;
   logic [WIDTH-1:0]   branch_target;
   logic [WIDTH-1:0]   pc_max;
   logic [WIDTH-1:0]   pc;
   logic               pc_valid;
   logic [1:0]         state;
   logic [DEPTH_W-1:0] depth;
   logic               overflow;
   logic               underflow;
   logic               bad_target;

   modport master (
      output start, halt_req, stall, branch, call, ret, branch_target, pc_max,
      input  pc, pc_valid, state, depth, overflow, underflow, bad_target
   );

   modport slave (
      input  start, halt_req, stall, branch, call, ret, branch_target, pc_max,
      output pc, pc_valid, state, depth, overflow, underflow, bad_target
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: start/halt, stall, branch, call/return through a
// small return-address stack, and wrap-around at a programmable pc_max.
module pc_sequencer #(
   parameter int WIDTH       = 32,
   parameter int STACK_DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   pc_sequencer_if.slave bus
);
   localparam int PTR_W   = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = PTR_W + 1;

   localparam logic [WIDTH-1:0]   PC_ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   PC_ONE     = WIDTH'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
   localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   pc_q, pc_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic               bad_target_q, bad_target_d;
   logic [WIDTH-1:0]   stack_q [STACK_DEPTH];

   logic               push_s;
   logic [PTR_W-1:0]   push_idx_s;
   logic [PTR_W-1:0]   top_idx_s;
   logic [WIDTH-1:0]   nxt_pc_s;
   logic               target_bad_s;
   logic               stack_full_s;
   logic               stack_empty_s;

   // The >= test wraps before pc+1 can overflow and also covers pc_max shrinking below pc.
   function automatic logic [WIDTH-1:0] next_pc(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] lim);
      logic [WIDTH-1:0] result;
      if (cur >= lim) begin
         result = PC_ZERO;
      end else begin
         result = cur + PC_ONE;
      end
      return result;
   endfunction

   assign nxt_pc_s      = next_pc(pc_q, bus.pc_max);
   assign target_bad_s  = (bus.branch_target > bus.pc_max);
   assign stack_full_s  = (depth_q == DEPTH_FULL);
   assign stack_empty_s = (depth_q == DEPTH_ZERO);
   assign push_idx_s    = depth_q[PTR_W-1:0];
   assign top_idx_s     = PTR_W'(depth_q - DEPTH_ONE);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      depth_d      = depth_q;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      bad_target_d = bad_target_q;
      push_s       = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (bus.start) begin
               state_d      = ST_RUN;
               pc_d         = PC_ZERO;
               depth_d      = DEPTH_ZERO;
               overflow_d   = 1'b0;
               underflow_d  = 1'b0;
               bad_target_d = 1'b0;
            end else if (state_q == ST_IDLE) begin
               pc_d = PC_ZERO;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_RUN: begin
            // Strict priority: exactly one request acts per cycle, the rest are dropped.
            if (bus.halt_req) begin
               state_d = ST_HALTED;
            end else if (bus.stall) begin
               pc_d = pc_q;
            end else if (bus.ret) begin
               if (stack_empty_s) begin
                  underflow_d = 1'b1;
                  pc_d        = PC_ZERO;
               end else begin
                  pc_d    = stack_q[top_idx_s];
                  depth_d = depth_q - DEPTH_ONE;
               end
            end else if (bus.call) begin
               if (stack_full_s) begin
                  overflow_d = 1'b1;
                  pc_d       = nxt_pc_s;
               end else if (target_bad_s) begin
                  bad_target_d = 1'b1;
                  pc_d         = PC_ZERO;
               end else begin
                  push_s  = 1'b1;
                  depth_d = depth_q + DEPTH_ONE;
                  pc_d    = bus.branch_target;
               end
            end else if (bus.branch) begin
               if (target_bad_s) begin
                  bad_target_d = 1'b1;
                  pc_d         = PC_ZERO;
               end else begin
                  pc_d = bus.branch_target;
               end
            end else begin
               pc_d = nxt_pc_s;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = PC_ZERO;
            depth_d = DEPTH_ZERO;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         pc_q         <= PC_ZERO;
         depth_q      <= DEPTH_ZERO;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         bad_target_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         depth_q      <= depth_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         bad_target_q <= bad_target_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= PC_ZERO;
         end
      end else if (push_s) begin
         stack_q[push_idx_s] <= nxt_pc_s;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_valid   = (state_q == ST_RUN) && !bus.stall;
   assign bus.state      = state_q;
   assign bus.depth      = depth_q;
   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
   assign bus.bad_target = bad_target_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that owns the program counter register and decides its next value every cycle.
- Function: start/halt control, stall hold, branch, call/return through a small return-address stack, and wrap-around at a programmable pc_max.
- Sits between the instruction decode/control logic (requesters) and the instruction memory address input (pc).

Parameters:
- WIDTH, 32, width of pc, pc_max and branch_target.
- STACK_DEPTH, 4, number of return-address stack entries (power of 2, >= 2).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse; IDLE/HALTED -> RUN, pc restarts at 0.
- halt_req  input  1  request to stop fetching.
- stall  input  1  hold pc for this cycle while in RUN.
- branch  input  1  jump to branch_target.
- call  input  1  push return address, then jump to branch_target.
- ret  input  1  pop return address into pc.
- branch_target  input  WIDTH  destination for branch/call.
- pc_max  input  WIDTH  last valid address; increment wraps to 0 after it.
- pc  output  WIDTH  current program counter.
- pc_valid  output  1  high in RUN when not stalled (pc is a fetch address).
- state  output  2  0=IDLE, 1=RUN, 2=HALTED.
- depth  output  log2(STACK_DEPTH)+1  stack occupancy.
- overflow  output  1  sticky; call attempted with stack full.
- underflow  output  1  sticky; ret attempted with stack empty.
- bad_target  output  1  sticky; branch/call target > pc_max.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=0, state=IDLE, depth=0, all sticky flags=0, pc_valid=0.
  - Stack contents are don't-care.
  - Reset mid-operation aborts immediately; no pending request survives.
- IDLE:
  - pc held at 0; all requests except start are ignored.
  - start -> RUN next cycle with pc=0; first pc_valid is that same cycle.
- HALTED:
  - pc frozen at its last value; depth is preserved.
  - start -> RUN with pc=0, depth=0, all sticky flags cleared.
- RUN, one action per cycle, strict priority:
  1. halt_req: state=HALTED, pc unchanged.
  2. stall: pc unchanged, pc_valid=0.
  3. ret:
     - depth>0: pc=top of stack, depth-1.
     - depth=0: underflow=1, pc=0.
  4. call:
     - Push nxt(pc) and set pc=branch_target.
     - depth=STACK_DEPTH: overflow=1, no push, pc=nxt(pc); the call is dropped.
  5. branch: pc=branch_target.
  6. Otherwise: pc=nxt(pc).
- Lower-priority requests asserted in the same cycle are discarded, not queued.
- nxt(pc):
  - (pc >= pc_max) ? 0 : pc+1, unsigned compare.
  - The >= covers pc_max being lowered below the current pc.
  - pc_max=0 keeps pc at 0.
- Target check: branch_target > pc_max on a taken branch/call -> bad_target=1 and pc=0; a call with a bad target does not push.
- Arithmetic: pc+1 is WIDTH bits; it cannot overflow because pc_max <= 2^WIDTH-1 and the >= test wraps first.
- Stack:
  - LIFO; push and pop never happen in the same cycle (guaranteed by the priority order).
  - depth ranges 0..STACK_DEPTH.
- Latency: every request takes effect on pc at the clock edge where it is sampled; one-cycle response, no bubbles.
- Outputs are registered except pc_valid, which is (state==RUN && !stall).

Test Plan:
- Wrap: pc_max=15, start, no requests for 20 cycles -> pc 0..15, 0..3; pc_valid=1 every cycle.
- Stall/halt priority: in RUN at pc=5, assert stall 3 cycles -> pc stays 5, pc_valid=0. Then halt_req together with branch(target 9) -> state=HALTED, pc=5. Then start -> pc=0, RUN.
- Call/return: at pc=3 call target 10 -> pc=10, depth=1. Run 2 cycles -> pc=12. ret -> pc=4, depth=0.
- Stack limits (STACK_DEPTH=4): 5 nested calls -> depth=4, overflow=1, fifth call advances pc by 1. Then 5 rets -> last ret gives pc=0, underflow=1. Both flags stay set until the next start.
- Bad target and pc_max shrink:
  - pc_max=15, branch to 20 -> pc=0, bad_target=1.
  - Run to pc=12, then set pc_max=8 -> next pc=0.
- Async reset mid-run: drop reset between clock edges while pc=7, depth=2 -> pc=0, state=IDLE, depth=0 immediately, without waiting for a clock edge. After release, pc stays 0 until start.
